// File: rtl/pipeline_control.sv
// Sequencing control for the LC-3b pipelined datapath. It drives the stage-buffer load enables,
// tracks per-stage valid bits, resolves stalls, hazards and flushes, and counts lost cycles.
module pipeline_control #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   imem_resp,
    input  logic [2:0]             id_src1,
    input  logic [2:0]             id_src2,
    input  logic                   id_uses_src1,
    input  logic                   id_uses_src2,
    input  logic [2:0]             ex_dest,
    input  logic                   ex_is_load,
    input  logic                   mem_is_mem,
    input  logic                   mem_indirect,
    input  logic                   mem_br_taken,
    input  logic                   dmem_resp,
    output logic                   dmem_stb,
    output logic                   dmem_phase,
    output logic                   load_pc,
    output logic                   load_if_id,
    output logic                   load_id_ex,
    output logic                   load_ex_mem,
    output logic                   load_mem_wb,
    output logic                   valid_id,
    output logic                   valid_ex,
    output logic                   valid_mem,
    output logic                   valid_wb,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    typedef enum logic {StFirst, StSecond} mem_state_e;

    mem_state_e state_q, state_d;
    logic valid_id_q, valid_id_d;
    logic valid_ex_q, valid_ex_d;
    logic valid_mem_q, valid_mem_d;
    logic valid_wb_q, valid_wb_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic mem_req, mem_done, mem_stall;
    logic src1_match, src2_match, hazard, flush, if_stall;
    logic ld_pc, ld_if_id, ld_id_ex, ld_ex_mem;

    always_comb begin
        mem_req    = valid_mem_q & mem_is_mem;
        mem_done   = dmem_resp & ((state_q == StSecond) | ~mem_indirect);
        mem_stall  = mem_req & ~mem_done;
        src1_match = id_uses_src1 & (id_src1 == ex_dest);
        src2_match = id_uses_src2 & (id_src2 == ex_dest);
        hazard     = valid_id_q & valid_ex_q & ex_is_load & (src1_match | src2_match);
        // A branch waiting on its own memory access must not redirect fetch yet.
        flush      = valid_mem_q & mem_br_taken & ~mem_stall;
        if_stall   = ~imem_resp;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFirst: begin
                if (mem_req & dmem_resp & mem_indirect) begin
                    state_d = StSecond;
                end
            end
            StSecond: begin
                if (mem_req & dmem_resp) begin
                    state_d = StFirst;
                end
            end
            default: state_d = StFirst;
        endcase
    end

    always_comb begin
        ld_pc       = 1'b1;
        ld_if_id    = 1'b1;
        ld_id_ex    = 1'b1;
        ld_ex_mem   = 1'b1;
        valid_id_d  = 1'b1;
        valid_ex_d  = valid_id_q;
        valid_mem_d = valid_ex_q;
        valid_wb_d  = valid_mem_q;
        if (mem_stall) begin
            // Freeze everything up to MEM; WB gets a bubble so writeback happens once.
            ld_pc       = 1'b0;
            ld_if_id    = 1'b0;
            ld_id_ex    = 1'b0;
            ld_ex_mem   = 1'b0;
            valid_id_d  = valid_id_q;
            valid_ex_d  = valid_ex_q;
            valid_mem_d = valid_mem_q;
            valid_wb_d  = 1'b0;
        end else if (flush) begin
            valid_id_d  = 1'b0;
            valid_ex_d  = 1'b0;
            valid_mem_d = 1'b0;
            valid_wb_d  = 1'b1;
        end else if (hazard) begin
            ld_pc      = 1'b0;
            ld_if_id   = 1'b0;
            valid_id_d = valid_id_q;
            valid_ex_d = 1'b0;
        end else if (if_stall) begin
            ld_pc      = 1'b0;
            valid_id_d = 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        if ((mem_stall | hazard | if_stall) && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFirst;
            valid_id_q  <= 1'b0;
            valid_ex_q  <= 1'b0;
            valid_mem_q <= 1'b0;
            valid_wb_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            valid_id_q  <= valid_id_d;
            valid_ex_q  <= valid_ex_d;
            valid_mem_q <= valid_mem_d;
            valid_wb_q  <= valid_wb_d;
            count_q     <= count_d;
        end
    end

    assign dmem_stb    = mem_req & ~reset;
    assign dmem_phase  = (state_q == StSecond);
    assign load_pc     = ld_pc & ~reset;
    assign load_if_id  = ld_if_id & ~reset;
    assign load_id_ex  = ld_id_ex & ~reset;
    assign load_ex_mem = ld_ex_mem & ~reset;
    assign load_mem_wb = ~reset;
    assign valid_id    = valid_id_q;
    assign valid_ex    = valid_ex_q;
    assign valid_mem   = valid_mem_q;
    assign valid_wb    = valid_wb_q;
    assign stall_count = count_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: a reference model predicts every cycle into a scoreboard queue,
// plus directed checks of the key points; a 4-bit-counter instance covers saturation.
module tb_pipeline_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, imem_resp, id_uses_src1, id_uses_src2, ex_is_load;
    logic mem_is_mem, mem_indirect, mem_br_taken, dmem_resp;
    logic [2:0] id_src1, id_src2, ex_dest;

    logic a_stb, a_phase, a_lpc, a_lifid, a_lidex, a_lexmem, a_lmemwb;
    logic a_vid, a_vex, a_vmem, a_vwb;
    logic [15:0] a_cnt;
    logic b_stb, b_phase, b_lpc, b_lifid, b_lidex, b_lexmem, b_lmemwb;
    logic b_vid, b_vex, b_vmem, b_vwb;
    logic [3:0] b_cnt;

    pipeline_control #(.COUNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .imem_resp(imem_resp),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
        .ex_dest(ex_dest), .ex_is_load(ex_is_load),
        .mem_is_mem(mem_is_mem), .mem_indirect(mem_indirect),
        .mem_br_taken(mem_br_taken), .dmem_resp(dmem_resp),
        .dmem_stb(a_stb), .dmem_phase(a_phase), .load_pc(a_lpc),
        .load_if_id(a_lifid), .load_id_ex(a_lidex), .load_ex_mem(a_lexmem),
        .load_mem_wb(a_lmemwb), .valid_id(a_vid), .valid_ex(a_vex),
        .valid_mem(a_vmem), .valid_wb(a_vwb), .stall_count(a_cnt)
    );

    pipeline_control #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .imem_resp(imem_resp),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
        .ex_dest(ex_dest), .ex_is_load(ex_is_load),
        .mem_is_mem(mem_is_mem), .mem_indirect(mem_indirect),
        .mem_br_taken(mem_br_taken), .dmem_resp(dmem_resp),
        .dmem_stb(b_stb), .dmem_phase(b_phase), .load_pc(b_lpc),
        .load_if_id(b_lifid), .load_id_ex(b_lidex), .load_ex_mem(b_lexmem),
        .load_mem_wb(b_lmemwb), .valid_id(b_vid), .valid_ex(b_vex),
        .valid_mem(b_vmem), .valid_wb(b_vwb), .stall_count(b_cnt)
    );

    // ctrl = {stb, phase, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}
    typedef struct packed {
        logic [6:0]  ctrl;
        logic [3:0]  valid;
        logic [15:0] cnt16;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb_q[$];
    int total = 0;
    int bad = 0;
    string step = "init";

    // Reference state: valid bits {id, ex, mem, wb}, MEM phase, both counters.
    logic [3:0] m_v = 4'b0000;
    bit m_second = 1'b0;
    int m_cnt16 = 0;
    int m_cnt4 = 0;

    logic [3:0] fill_seq [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_resp = 1'b1;
        id_src1 = 3'd0; id_src2 = 3'd0; id_uses_src1 = 1'b0; id_uses_src2 = 1'b0;
        ex_dest = 3'd0; ex_is_load = 1'b0;
        mem_is_mem = 1'b0; mem_indirect = 1'b0; mem_br_taken = 1'b0; dmem_resp = 1'b0;
    endtask

    // One clock: predict, push, sample at the falling edge, pop and compare, advance the model.
    task automatic tick();
        exp_t e, p;
        logic [3:0] ld, nv;
        bit req, done, mst, hz, fl, ifs;
        req  = m_v[1] & mem_is_mem;
        done = dmem_resp & (m_second | !mem_indirect);
        mst  = req & !done;
        hz   = m_v[3] & m_v[2] & ex_is_load &
               ((id_uses_src1 && id_src1 == ex_dest) || (id_uses_src2 && id_src2 == ex_dest));
        fl   = m_v[1] & mem_br_taken & !mst;
        ifs  = !imem_resp;
        if (mst) ld = 4'b0000;
        else if (fl) ld = 4'b1111;
        else if (hz) ld = 4'b0011;
        else if (ifs) ld = 4'b0111;
        else ld = 4'b1111;
        e.ctrl  = reset ? {1'b0, m_second, 5'b00000} : {req, m_second, ld, 1'b1};
        e.valid = m_v;
        e.cnt16 = 16'(m_cnt16);
        e.cnt4  = 4'(m_cnt4);
        sb_q.push_back(e);

        @(negedge clk);
        p = sb_q.pop_front();
        check("ctrl", 32'({a_stb, a_phase, a_lpc, a_lifid, a_lidex, a_lexmem, a_lmemwb}),
              32'(p.ctrl));
        check("valid", 32'({a_vid, a_vex, a_vmem, a_vwb}), 32'(p.valid));
        check("count", 32'(a_cnt), 32'(p.cnt16));
        check("ctrl4", 32'({b_stb, b_phase, b_lpc, b_lifid, b_lidex, b_lexmem, b_lmemwb}),
              32'(p.ctrl));
        check("valid4", 32'({b_vid, b_vex, b_vmem, b_vwb}), 32'(p.valid));
        check("count4", 32'(b_cnt), 32'(p.cnt4));

        if (reset) begin
            m_v = 4'b0000; m_second = 1'b0; m_cnt16 = 0; m_cnt4 = 0;
        end else begin
            if (mst) nv = {m_v[3], m_v[2], m_v[1], 1'b0};
            else if (fl) nv = 4'b0001;
            else if (hz) nv = {m_v[3], 1'b0, m_v[2], m_v[1]};
            else if (ifs) nv = {1'b0, m_v[3], m_v[2], m_v[1]};
            else nv = {1'b1, m_v[3], m_v[2], m_v[1]};
            if (req && dmem_resp) m_second = m_second ? 1'b0 : mem_indirect;
            if (mst || hz || ifs) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            m_v = nv;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] valids();
        return 32'({a_vid, a_vex, a_vmem, a_vwb});
    endfunction

    initial begin
        fill_seq[0] = 4'b1000; fill_seq[1] = 4'b1100;
        fill_seq[2] = 4'b1110; fill_seq[3] = 4'b1111;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;

        step = "reset";
        check("loads_in_reset", 32'({a_lpc, a_lifid, a_lidex, a_lexmem, a_lmemwb, a_stb}), 32'd0);
        tick();
        tick();
        check("valid", valids(), 32'd0);
        check("count", 32'(a_cnt), 32'd0);

        step = "fill";
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("valid", valids(), 32'(fill_seq[i]));
        end
        check("count", 32'(a_cnt), 32'd0);

        step = "load_use";
        ex_is_load = 1'b1; ex_dest = 3'd3; id_src1 = 3'd3; id_uses_src1 = 1'b1;
        #1;
        check("pc_if", 32'({a_lpc, a_lifid, a_lidex}), 32'b001);
        tick();
        check("valid", valids(), 32'b1011);
        check("count", 32'(a_cnt), 32'd1);
        ex_is_load = 1'b0; id_uses_src1 = 1'b0;
        #1;
        check("pc_after", 32'(a_lpc), 32'd1);
        repeat (3) tick();
        check("refill", valids(), 32'b1111);

        step = "ldi";
        mem_is_mem = 1'b1; mem_indirect = 1'b1; dmem_resp = 1'b0;
        tick();
        check("valid1", valids(), 32'b1110);
        check("phase1", 32'(a_phase), 32'd0);
        dmem_resp = 1'b1;
        tick();
        check("phase2", 32'(a_phase), 32'd1);
        dmem_resp = 1'b0;
        #1;
        check("frozen", 32'({a_lpc, a_lifid, a_lidex, a_lexmem}), 32'd0);
        tick();
        check("valid3", valids(), 32'b1110);
        dmem_resp = 1'b1;
        #1;
        check("done_pc", 32'(a_lpc), 32'd1);
        tick();
        check("phase4", 32'(a_phase), 32'd0);
        check("valid4", valids(), 32'b1111);
        check("count", 32'(a_cnt), 32'd4);

        step = "zero_latency";
        mem_indirect = 1'b0;
        #1;
        check("stb_pc", 32'({a_stb, a_lpc}), 32'b11);
        tick();
        check("count", 32'(a_cnt), 32'd4);
        mem_is_mem = 1'b0; dmem_resp = 1'b0;

        step = "flush";
        mem_br_taken = 1'b1;
        #1;
        check("load_pc", 32'(a_lpc), 32'd1);
        tick();
        check("valid", valids(), 32'b0001);
        mem_br_taken = 1'b0;
        repeat (4) tick();
        check("refill", valids(), 32'b1111);

        step = "stalled_branch";
        mem_is_mem = 1'b1; mem_br_taken = 1'b1;
        #1;
        check("no_flush", 32'(a_lpc), 32'd0);
        tick();
        check("valid", valids(), 32'b1110);
        dmem_resp = 1'b1;
        #1;
        check("flush_pc", 32'(a_lpc), 32'd1);
        tick();
        check("flushed", valids(), 32'b0001);
        check("count", 32'(a_cnt), 32'd5);
        idle_inputs();
        repeat (4) tick();

        step = "if_stall";
        imem_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("load_pc", 32'(a_lpc), 32'd0);
            tick();
        end
        check("valid", valids(), 32'b0001);
        check("count", 32'(a_cnt), 32'd8);

        step = "saturate";
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i >= 7) check("sat4", 32'(b_cnt), 32'd15);
        end
        check("count16", 32'(a_cnt), 32'd28);

        step = "reset_in_second";
        imem_resp = 1'b1;
        repeat (3) tick();
        mem_is_mem = 1'b1; mem_indirect = 1'b1; dmem_resp = 1'b1;
        tick();
        check("phase", 32'(a_phase), 32'd1);
        check("count16", 32'(a_cnt), 32'd29);
        reset = 1'b1; dmem_resp = 1'b0;
        tick();
        check("phase", 32'(a_phase), 32'd0);
        check("count16", 32'(a_cnt), 32'd0);
        check("count4", 32'(b_cnt), 32'd0);
        check("valid", valids(), 32'd0);
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("restart", valids(), 32'b1100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
